// File: rtl/fu_wb_stage_multi.sv
// Multi-channel writeback register stage: one DEPTH-entry FIFO per FU channel feeding the
// PRF write ports and ROB finish strobes, with valid/ready backpressure and flush.
module fu_wb_stage_multi #(
    parameter int NCH    = 4,
    parameter int DEPTH  = 2,
    parameter int DW     = 32,
    parameter int PRF_AW = 6,
    parameter int ROB_AW = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [NCH-1:0]                       in_valid,
    output logic [NCH-1:0]                       in_ready,
    input  logic [NCH-1:0]                       in_prf_wen,
    input  logic [NCH*PRF_AW-1:0]                in_prf_addr,
    input  logic [NCH*DW-1:0]                    in_prf_data,
    input  logic [NCH*ROB_AW-1:0]                in_rob_id,
    input  logic [NCH-1:0]                       out_ready,
    output logic [NCH-1:0]                       out_valid,
    output logic [NCH-1:0]                       out_prf_wen,
    output logic [NCH*PRF_AW-1:0]                out_prf_addr,
    output logic [NCH*DW-1:0]                    out_prf_data,
    output logic [NCH-1:0]                       out_set_finish,
    output logic [NCH*ROB_AW-1:0]                out_rob_id,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + PRF_AW + DW + ROB_AW;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [EW-1:0] mem_q [DEPTH];
        logic [PW-1:0] wptr_q, wptr_d;
        logic [PW-1:0] rptr_q, rptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          push, pop;
        logic [EW-1:0] wr_entry, head;

        // Entry layout, MSB first: {prf_wen, prf_addr, prf_data, rob_id}
        assign wr_entry = {in_prf_wen[c],
                           in_prf_addr[c*PRF_AW +: PRF_AW],
                           in_prf_data[c*DW +: DW],
                           in_rob_id[c*ROB_AW +: ROB_AW]};
        assign head     = mem_q[rptr_q];

        // Handshake flags come only from the registered count, so no ready/valid comb loop.
        assign in_ready[c]  = (cnt_q < CW'(DEPTH));
        assign out_valid[c] = (cnt_q != '0);
        assign push         = in_valid[c] & in_ready[c];
        assign pop          = out_valid[c] & out_ready[c];

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            if (push && !pop)      cnt_d = cnt_q + CW'(1);
            else if (!push && pop) cnt_d = cnt_q - CW'(1);
        end

        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Storage is never reset; the cleared count hides any stale contents.
        always_ff @(posedge clk) begin
            if (push) mem_q[wptr_q] <= wr_entry;
        end

        assign out_prf_wen[c]                    = out_valid[c] & head[EW-1];
        assign out_prf_addr[c*PRF_AW +: PRF_AW]  = head[EW-2 -: PRF_AW];
        assign out_prf_data[c*DW +: DW]          = head[ROB_AW +: DW];
        assign out_rob_id[c*ROB_AW +: ROB_AW]    = head[ROB_AW-1:0];
        assign out_set_finish[c]                 = out_valid[c];
        assign occupancy[c*CW +: CW]             = cnt_q;
    end

endmodule

// File: tb/tb_fu_wb_stage_multi.sv
// Directed bench for fu_wb_stage_multi: a vector table of per-cycle stimulus and expected
// post-edge state, followed by hand-written streaming and full-with-pop sequences.
module tb_fu_wb_stage_multi;

    localparam int NCH = 4, DEPTH = 2, DW = 32, PRF_AW = 6, ROB_AW = 6;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n, flush;
    logic [NCH-1:0]        in_valid, in_ready, in_prf_wen, out_ready;
    logic [NCH*PRF_AW-1:0] in_prf_addr, out_prf_addr;
    logic [NCH*DW-1:0]     in_prf_data, out_prf_data;
    logic [NCH*ROB_AW-1:0] in_rob_id, out_rob_id;
    logic [NCH-1:0]        out_valid, out_prf_wen, out_set_finish;
    logic [NCH*CW-1:0]     occupancy;

    int checks   = 0;
    int failures = 0;

    fu_wb_stage_multi #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW), .PRF_AW(PRF_AW), .ROB_AW(ROB_AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_prf_wen(in_prf_wen),
        .in_prf_addr(in_prf_addr), .in_prf_data(in_prf_data), .in_rob_id(in_rob_id),
        .out_ready(out_ready), .out_valid(out_valid), .out_prf_wen(out_prf_wen),
        .out_prf_addr(out_prf_addr), .out_prf_data(out_prf_data),
        .out_set_finish(out_set_finish), .out_rob_id(out_rob_id), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        flush;
        logic [3:0]  vld;
        logic [3:0]  wen;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [5:0]  rob;
        logic [3:0]  ordy;
        logic [3:0]  e_ovld;
        logic [3:0]  e_irdy;
        logic [7:0]  e_occ;
        logic [3:0]  e_pwen;
        int          hch;
        logic [5:0]  e_addr;
        logic [31:0] e_data;
        logic [5:0]  e_rob;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rn, input logic fl, input logic [3:0] vld,
                       input logic [3:0] wen, input logic [5:0] addr, input logic [31:0] data,
                       input logic [5:0] rob, input logic [3:0] ordy, input logic [3:0] e_ovld,
                       input logic [3:0] e_irdy, input logic [7:0] e_occ, input logic [3:0] e_pwen,
                       input int hch, input logic [5:0] e_addr, input logic [31:0] e_data,
                       input logic [5:0] e_rob);
        vec_t v;
        v.name = nm; v.rst_n = rn; v.flush = fl; v.vld = vld; v.wen = wen; v.addr = addr;
        v.data = data; v.rob = rob; v.ordy = ordy; v.e_ovld = e_ovld; v.e_irdy = e_irdy;
        v.e_occ = e_occ; v.e_pwen = e_pwen; v.hch = hch; v.e_addr = e_addr; v.e_data = e_data;
        v.e_rob = e_rob;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Same addr/data/rob is presented on every channel; in_valid selects who pushes.
    task automatic drive(input logic rn, input logic fl, input logic [3:0] vld, input logic [3:0] wen,
                         input logic [5:0] addr, input logic [31:0] data, input logic [5:0] rob,
                         input logic [3:0] ordy);
        rst_n = rn; flush = fl; in_valid = vld; in_prf_wen = wen; out_ready = ordy;
        for (int c = 0; c < NCH; c++) begin
            in_prf_addr[c*PRF_AW +: PRF_AW] = addr;
            in_prf_data[c*DW +: DW]         = data;
            in_rob_id[c*ROB_AW +: ROB_AW]   = rob;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string nm, input int ch, input logic [5:0] a,
                            input logic [31:0] d, input logic [5:0] r);
        chk({nm, ".addr"}, 64'(out_prf_addr[ch*PRF_AW +: PRF_AW]), 64'(a));
        chk({nm, ".data"}, 64'(out_prf_data[ch*DW +: DW]), 64'(d));
        chk({nm, ".rob"},  64'(out_rob_id[ch*ROB_AW +: ROB_AW]), 64'(r));
    endtask

    initial begin
        //   name        rn fl vld   wen   addr data          rob ordy  ovld  irdy  occ    pwen  hch eaddr edata         erob
        add("rst0",      0, 0, 4'hF, 4'hF, 1,  32'h1,        1,  4'h0, 4'h0, 4'hF, 8'h00, 4'h0, 0, 0,  32'h0,        0);
        add("rst1",      0, 0, 4'hF, 4'hF, 1,  32'h1,        1,  4'h0, 4'h0, 4'hF, 8'h00, 4'h0, 0, 0,  32'h0,        0);
        add("lat_push",  1, 0, 4'h1, 4'h1, 5,  32'hDEADBEEF, 3,  4'hF, 4'h1, 4'hF, 8'h01, 4'h1, 0, 5,  32'hDEADBEEF, 3);
        add("lat_drain", 1, 0, 4'h0, 4'h0, 0,  32'h0,        0,  4'hF, 4'h0, 4'hF, 8'h00, 4'h0, 0, 0,  32'h0,        0);
        add("bp_A",      1, 0, 4'h2, 4'h2, 10, 32'h000000A1, 11, 4'h0, 4'h2, 4'hF, 8'h04, 4'h2, 1, 10, 32'h000000A1, 11);
        add("bp_B",      1, 0, 4'h2, 4'h2, 12, 32'h000000B2, 13, 4'h0, 4'h2, 4'hD, 8'h08, 4'h2, 1, 10, 32'h000000A1, 11);
        add("bp_C_rej",  1, 0, 4'h2, 4'h2, 14, 32'h000000C3, 15, 4'h0, 4'h2, 4'hD, 8'h08, 4'h2, 1, 10, 32'h000000A1, 11);
        add("bp_popA",   1, 0, 4'h0, 4'h0, 0,  32'h0,        0,  4'hF, 4'h2, 4'hF, 8'h04, 4'h2, 1, 12, 32'h000000B2, 13);
        add("bp_popB",   1, 0, 4'h0, 4'h0, 0,  32'h0,        0,  4'hF, 4'h0, 4'hF, 8'h00, 4'h0, 1, 0,  32'h0,        0);
        add("bp_C_again",1, 0, 4'h2, 4'h2, 14, 32'h000000C3, 15, 4'h0, 4'h2, 4'hF, 8'h04, 4'h2, 1, 14, 32'h000000C3, 15);
        add("bp_popC",   1, 0, 4'h0, 4'h0, 0,  32'h0,        0,  4'hF, 4'h0, 4'hF, 8'h00, 4'h0, 1, 0,  32'h0,        0);
        add("pp_X",      1, 0, 4'h4, 4'h4, 20, 32'h11112222, 21, 4'h0, 4'h4, 4'hF, 8'h10, 4'h4, 2, 20, 32'h11112222, 21);
        add("pp_Y",      1, 0, 4'h4, 4'h4, 22, 32'h33334444, 23, 4'h4, 4'h4, 4'hF, 8'h10, 4'h4, 2, 22, 32'h33334444, 23);
        add("pp_drain",  1, 0, 4'h0, 4'h0, 0,  32'h0,        0,  4'hF, 4'h0, 4'hF, 8'h00, 4'h0, 2, 0,  32'h0,        0);
        add("nowr",      1, 0, 4'h8, 4'h0, 7,  32'h00000055, 9,  4'h0, 4'h8, 4'hF, 8'h40, 4'h0, 3, 7,  32'h00000055, 9);
        add("fill1",     1, 0, 4'hF, 4'hF, 30, 32'h0000F0F0, 31, 4'h0, 4'hF, 4'h7, 8'h95, 4'h7, 3, 7,  32'h00000055, 9);
        add("fill2",     1, 0, 4'hF, 4'hF, 32, 32'h0000ABCD, 33, 4'h0, 4'hF, 4'h0, 8'hAA, 4'h7, 0, 30, 32'h0000F0F0, 31);
        add("flush",     1, 1, 4'hF, 4'hF, 34, 32'h0000EEEE, 35, 4'hF, 4'h0, 4'hF, 8'h00, 4'h0, 0, 0,  32'h0,        0);
        add("post_fl",   1, 0, 4'h0, 4'h0, 0,  32'h0,        0,  4'hF, 4'h0, 4'hF, 8'h00, 4'h0, 0, 0,  32'h0,        0);
        add("stall",     1, 0, 4'h2, 4'h2, 40, 32'h00004040, 41, 4'h0, 4'h2, 4'hF, 8'h04, 4'h2, 1, 40, 32'h00004040, 41);
        add("rst_fl",    0, 1, 4'h2, 4'h2, 42, 32'h00004242, 43, 4'h0, 4'h0, 4'hF, 8'h00, 4'h0, 1, 0,  32'h0,        0);
        add("post_rst",  1, 0, 4'h1, 4'h1, 50, 32'h00005050, 51, 4'h0, 4'h1, 4'hF, 8'h01, 4'h1, 0, 50, 32'h00005050, 51);

        rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_prf_wen = '0; out_ready = '0;
        in_prf_addr = '0; in_prf_data = '0; in_rob_id = '0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst_n, v.flush, v.vld, v.wen, v.addr, v.data, v.rob, v.ordy);
            chk({v.name, ".out_valid"}, 64'(out_valid), 64'(v.e_ovld));
            chk({v.name, ".set_finish"}, 64'(out_set_finish), 64'(v.e_ovld));
            chk({v.name, ".in_ready"}, 64'(in_ready), 64'(v.e_irdy));
            chk({v.name, ".occupancy"}, 64'(occupancy), 64'(v.e_occ));
            chk({v.name, ".prf_wen"}, 64'(out_prf_wen), 64'(v.e_pwen));
            if (v.e_ovld[v.hch]) chk_head(v.name, v.hch, v.e_addr, v.e_data, v.e_rob);
        end

        // Streaming on ch2 with the sink always ready: pointers wrap several times, order kept.
        drive(1, 1, 4'h0, 4'h0, 0, 32'h0, 0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 4'h4, 4'h4, 6'(k), 32'h1000 + 32'(k), 6'(k + 16), 4'h4);
            chk("stream.occ", 64'(occupancy[2*CW +: CW]), 64'd1);
            chk_head("stream", 2, 6'(k), 32'h1000 + 32'(k), 6'(k + 16));
        end

        // Full ch0 with a pop in the same cycle as an offer: offer dropped, ready returns next cycle.
        drive(1, 1, 4'h0, 4'h0, 0, 32'h0, 0, 4'h0);
        drive(1, 0, 4'h1, 4'h1, 1, 32'hAAAA0001, 1, 4'h0);
        drive(1, 0, 4'h1, 4'h1, 2, 32'hAAAA0002, 2, 4'h0);
        chk("full.in_ready", 64'(in_ready[0]), 64'd0);
        drive(1, 0, 4'h1, 4'h1, 3, 32'hAAAA0003, 3, 4'h1);
        chk("fullpop.occ", 64'(occupancy[0 +: CW]), 64'd1);
        chk("fullpop.in_ready", 64'(in_ready[0]), 64'd1);
        chk_head("fullpop", 0, 2, 32'hAAAA0002, 2);
        drive(1, 0, 4'h1, 4'h1, 3, 32'hAAAA0003, 3, 4'h0);
        chk("reoffer.occ", 64'(occupancy[0 +: CW]), 64'd2);
        drive(1, 0, 4'h0, 4'h0, 0, 32'h0, 0, 4'h1);
        chk_head("order2", 0, 3, 32'hAAAA0003, 3);
        drive(1, 0, 4'h0, 4'h0, 0, 32'h0, 0, 4'h1);
        chk("drained.out_valid", 64'(out_valid[0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
